port_io_responder: RTL

//  Peripheral end of the 4-bit CPU port bus. Decodes port_id/port_read/port_write

---
 rtl/port_io_responder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/port_io_responder.sv
// rtl/port_io_responder.sv - peripheral end of the CPU port bus: output latches, synced inputs, TX FIFO, status
// Optional feature macro: PORT_IRQ_EN adds the registered irq output.
module port_io_responder #(
    parameter int DATA_WIDTH  = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [2:0]              port_id,
    input  logic                    port_read,
    input  logic                    port_write,
    input  logic [DATA_WIDTH-1:0]   data_from_cpu,
    output logic [DATA_WIDTH-1:0]   data_to_cpu,
    output logic [4*DATA_WIDTH-1:0] out_ports,
    input  logic [2*DATA_WIDTH-1:0] in_ports,
    output logic [DATA_WIDTH-1:0]   fifo_data,
    output logic                    fifo_valid,
    input  logic                    fifo_ready
`ifdef PORT_IRQ_EN
    ,
    output logic                    irq
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0]   r_out  [4];
    logic [2*DATA_WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [DATA_WIDTH-1:0]   r_mem  [FIFO_DEPTH];
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;
    logic                    r_ovf;
    logic                    r_chg;

    logic                    w_wr_ok;
    logic                    w_rd_ok;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_ovf_set;
    logic                    w_w1c;
    logic                    w_chg_det;
    logic [2*DATA_WIDTH-1:0] w_sync_val;
    logic [DATA_WIDTH-1:0]   w_rd_data;

    // Simultaneous read and write strobes are a protocol error and act as neither.
    assign w_wr_ok    = port_write & ~port_read;
    assign w_rd_ok    = port_read & ~port_write;
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_pop      = fifo_valid & fifo_ready;
    assign w_push     = w_wr_ok & (port_id == 3'd6) & (~w_full | w_pop);
    assign w_ovf_set  = w_wr_ok & (port_id == 3'd6) & w_full & ~w_pop;
    assign w_w1c      = w_wr_ok & (port_id == 3'd7);
    assign w_sync_val = r_sync[SYNC_STAGES-1];
    // Last two stages differ: the readable value changes at this edge, so flag it now.
    assign w_chg_det  = (r_sync[SYNC_STAGES-1] != r_sync[SYNC_STAGES-2]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) r_out[i] <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= in_ports;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            if (w_wr_ok && !port_id[2]) r_out[port_id[1:0]] <= data_from_cpu;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= data_from_cpu;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
            r_chg <= 1'b0;
        end else begin
            if (w_ovf_set)                    r_ovf <= 1'b1;
            else if (w_w1c && data_from_cpu[3]) r_ovf <= 1'b0;
            if (w_chg_det)                    r_chg <= 1'b1;
            else if (w_w1c && data_from_cpu[2]) r_chg <= 1'b0;
        end
    end

    always_comb begin
        w_rd_data = '0;
        if (w_rd_ok) begin
            case (port_id)
                3'd0, 3'd1, 3'd2, 3'd3: w_rd_data = r_out[port_id[1:0]];
                3'd4:    w_rd_data = w_sync_val[DATA_WIDTH-1:0];
                3'd5:    w_rd_data = w_sync_val[2*DATA_WIDTH-1:DATA_WIDTH];
                3'd6:    w_rd_data = DATA_WIDTH'(r_count);
                default: w_rd_data = DATA_WIDTH'({r_ovf, r_chg, w_full, w_empty});
            endcase
        end
    end

    assign data_to_cpu = w_rd_data;
    assign out_ports   = {r_out[3], r_out[2], r_out[1], r_out[0]};
    assign fifo_data   = r_mem[r_rd_ptr];
    assign fifo_valid  = ~w_empty;

`ifdef PORT_IRQ_EN
    logic r_irq;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_irq <= 1'b0;
        else        r_irq <= r_ovf | r_chg;
    end
    assign irq = r_irq;
`endif

endmodule
